// File: rtl/sprite_queue.sv
// sprite_queue: a FIFO of sprite draw commands that releases them to sprite_driver one
// frame at a time. The producer enqueues commands, and a commit pulse publishes them to
// the driver. Three pointers split the ring into two regions:
//   rd_ptr .. cm_ptr : entries the driver can see
//   cm_ptr .. wr_ptr : entries enqueued but not yet committed
// Each pointer carries one extra wrap bit, so a full ring can be told apart from an empty one.
module sprite_queue #(
    parameter int DEPTH   = 64,
    parameter int ID_W    = 8,
    parameter int COORD_W = 16,
    parameter int SCALE_W = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    // producer side
    input  logic                    enq_valid,
    output logic                    enq_ready,
    input  logic [ID_W-1:0]         enq_id,
    input  logic [COORD_W-1:0]      enq_x,
    input  logic [COORD_W-1:0]      enq_y,
    input  logic [SCALE_W-1:0]      enq_scale,
    input  logic                    commit,
    input  logic                    flush,
    // driver side
    input  logic                    sprite_queue_dequeue,
    output logic                    sprite_queue_is_empty,
    output logic [ID_W-1:0]         sprite_queue_sprite_id,
    output logic [COORD_W-1:0]      sprite_queue_sprite_x,
    output logic [COORD_W-1:0]      sprite_queue_sprite_y,
    output logic [SCALE_W-1:0]      sprite_queue_sprite_scale,
    // status
    output logic [$clog2(DEPTH):0]  visible_count,
    output logic [$clog2(DEPTH):0]  pending_count,
    output logic                    overflow,
    output logic                    underflow,
    input  logic                    clear_status
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef logic [PW-1:0] ptr_t;

    typedef struct packed {
        logic [ID_W-1:0]    id;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [SCALE_W-1:0] scale;
    } entry_t;

    entry_t mem_q [DEPTH];

    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t cm_ptr_q, cm_ptr_d;
    ptr_t wr_ptr_q, wr_ptr_d;
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    ptr_t   used;
    ptr_t   wr_ptr_adv;
    logic   full;
    logic   is_empty;
    logic   enq_fire;
    logic   deq_fire;
    entry_t head;

    // Status decoded from the registered pointers only, so a pop in the same cycle
    // does not free a slot for an enqueue until the following cycle.
    always_comb begin
        used       = wr_ptr_q - rd_ptr_q;
        full       = (used == ptr_t'(DEPTH));
        is_empty   = (rd_ptr_q == cm_ptr_q);
        enq_fire   = enq_valid && !full;
        deq_fire   = sprite_queue_dequeue && !is_empty;
        wr_ptr_adv = wr_ptr_q + ptr_t'(enq_fire);
    end

    // Next-state pointer and flag logic. Flush overrides every pointer move, and a
    // sticky flag set by an error in this cycle wins over clear_status.
    always_comb begin
        rd_ptr_d    = rd_ptr_q + ptr_t'(deq_fire);
        wr_ptr_d    = wr_ptr_adv;
        cm_ptr_d    = commit ? wr_ptr_adv : cm_ptr_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (flush) begin
            rd_ptr_d = '0;
            cm_ptr_d = '0;
            wr_ptr_d = '0;
        end

        if (clear_status) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (enq_valid && full) begin
            overflow_d = 1'b1;
        end
        if (sprite_queue_dequeue && is_empty) begin
            underflow_d = 1'b1;
        end
    end

    // Pointer and flag registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments for all sequential state, so every register
        // samples values from before the clock edge regardless of statement order.
        if (reset) begin
            rd_ptr_q    <= '0;
            cm_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_ptr_q    <= rd_ptr_d;
            cm_ptr_q    <= cm_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Command storage write port.
    always_ff @(posedge clock) begin
        // NOTE: storage has no reset. Slots are only read after they have been written,
        // so clearing them would cost a wide reset fan-out and buy nothing.
        if (enq_fire && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= '{id: enq_id, x: enq_x, y: enq_y, scale: enq_scale};
        end
    end

    // Show-ahead head and status outputs. The head data is a don't-care while the queue is empty.
    always_comb begin
        head                      = mem_q[rd_ptr_q[AW-1:0]];
        sprite_queue_sprite_id    = head.id;
        sprite_queue_sprite_x     = head.x;
        sprite_queue_sprite_y     = head.y;
        sprite_queue_sprite_scale = head.scale;
        sprite_queue_is_empty     = is_empty;
        enq_ready                 = !full;
        visible_count             = cm_ptr_q - rd_ptr_q;
        pending_count             = wr_ptr_q - cm_ptr_q;
        overflow                  = overflow_q;
        underflow                 = underflow_q;
    end

endmodule

// File: tb/tb_sprite_queue.sv
// Directed testbench for sprite_queue (DEPTH=64). Inputs are driven 1ns after the
// rising edge, and outputs are sampled at the same point, once the registers have settled.
module tb_sprite_queue;

    localparam int DEPTH   = 64;
    localparam int ID_W    = 8;
    localparam int COORD_W = 16;
    localparam int SCALE_W = 8;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic               clock = 1'b0;
    logic               reset;
    logic               enq_valid;
    logic               enq_ready;
    logic [ID_W-1:0]    enq_id;
    logic [COORD_W-1:0] enq_x;
    logic [COORD_W-1:0] enq_y;
    logic [SCALE_W-1:0] enq_scale;
    logic               commit;
    logic               flush;
    logic               dequeue;
    logic               is_empty;
    logic [ID_W-1:0]    head_id;
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;
    logic [SCALE_W-1:0] head_scale;
    logic [CW-1:0]      visible_count;
    logic [CW-1:0]      pending_count;
    logic               overflow;
    logic               underflow;
    logic               clear_status;

    int checks = 0;
    int errors = 0;

    sprite_queue #(.DEPTH(DEPTH), .ID_W(ID_W), .COORD_W(COORD_W), .SCALE_W(SCALE_W)) dut (
        .clock                     (clock),
        .reset                     (reset),
        .enq_valid                 (enq_valid),
        .enq_ready                 (enq_ready),
        .enq_id                    (enq_id),
        .enq_x                     (enq_x),
        .enq_y                     (enq_y),
        .enq_scale                 (enq_scale),
        .commit                    (commit),
        .flush                     (flush),
        .sprite_queue_dequeue      (dequeue),
        .sprite_queue_is_empty     (is_empty),
        .sprite_queue_sprite_id    (head_id),
        .sprite_queue_sprite_x     (head_x),
        .sprite_queue_sprite_y     (head_y),
        .sprite_queue_sprite_scale (head_scale),
        .visible_count             (visible_count),
        .pending_count             (pending_count),
        .overflow                  (overflow),
        .underflow                 (underflow),
        .clear_status              (clear_status)
    );

    always #5 clock = ~clock;

    // Return all inputs to idle.
    task automatic idle();
        reset        = 1'b0;
        enq_valid    = 1'b0;
        enq_id       = '0;
        enq_x        = '0;
        enq_y        = '0;
        enq_scale    = '0;
        commit       = 1'b0;
        flush        = 1'b0;
        dequeue      = 1'b0;
        clear_status = 1'b0;
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one command with optional commit/dequeue for a single cycle.
    task automatic push(input int id, input int x, input int y, input int s,
                        input bit cm, input bit dq);
        enq_valid = 1'b1;
        enq_id    = ID_W'(id);
        enq_x     = COORD_W'(x);
        enq_y     = COORD_W'(y);
        enq_scale = SCALE_W'(s);
        commit    = cm;
        dequeue   = dq;
        tick();
        idle();
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        checks++;
        if (is_empty !== 1'b1 || enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: is_empty=%b enq_ready=%b expected 1 1", is_empty, enq_ready);
        end
        checks++;
        if (visible_count !== CW'(0) || pending_count !== CW'(0)) begin
            errors++;
            $display("FAIL reset_counts: visible=%0d pending=%0d expected 0 0", visible_count, pending_count);
        end
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_sticky: overflow=%b underflow=%b expected 0 0", overflow, underflow);
        end
    endtask

    task automatic test_commit_batch();
        for (int i = 1; i <= 3; i++) push(i, i * 16 + 1, i * 32 + 2, i + 10, 1'b0, 1'b0);
        checks++;
        if (is_empty !== 1'b1 || pending_count !== CW'(3) || visible_count !== CW'(0)) begin
            errors++;
            $display("FAIL precommit: is_empty=%b pending=%0d visible=%0d expected 1 3 0",
                     is_empty, pending_count, visible_count);
        end
        commit = 1'b1;
        tick();
        idle();
        checks++;
        if (is_empty !== 1'b0 || head_id !== ID_W'(1) || visible_count !== CW'(3) ||
            pending_count !== CW'(0)) begin
            errors++;
            $display("FAIL commit: is_empty=%b id=%0d visible=%0d pending=%0d expected 0 1 3 0",
                     is_empty, head_id, visible_count, pending_count);
        end
    endtask

    task automatic test_pop_order();
        for (int i = 1; i <= 3; i++) begin
            checks++;
            if (head_id !== ID_W'(i) || head_x !== COORD_W'(i * 16 + 1) ||
                head_y !== COORD_W'(i * 32 + 2) || head_scale !== SCALE_W'(i + 10)) begin
                errors++;
                $display("FAIL pop_head%0d: id=%0d x=%0d y=%0d s=%0d expected %0d %0d %0d %0d",
                         i, head_id, head_x, head_y, head_scale, i, i * 16 + 1, i * 32 + 2, i + 10);
            end
            dequeue = 1'b1;
            tick();
            idle();
            tick();
        end
        checks++;
        if (is_empty !== 1'b1 || visible_count !== CW'(0) || underflow !== 1'b0) begin
            errors++;
            $display("FAIL drained: is_empty=%b visible=%0d underflow=%b expected 1 0 0",
                     is_empty, visible_count, underflow);
        end
        dequeue = 1'b1;
        tick();
        idle();
        checks++;
        if (underflow !== 1'b1 || visible_count !== CW'(0) || pending_count !== CW'(0) ||
            is_empty !== 1'b1) begin
            errors++;
            $display("FAIL underflow: underflow=%b visible=%0d pending=%0d is_empty=%b expected 1 0 0 1",
                     underflow, visible_count, pending_count, is_empty);
        end
        // An error in the same cycle as clear_status keeps the flag set.
        clear_status = 1'b1;
        dequeue      = 1'b1;
        tick();
        idle();
        checks++;
        if (underflow !== 1'b1) begin
            errors++;
            $display("FAIL clear_vs_error: underflow=%b expected 1", underflow);
        end
        clear_status = 1'b1;
        tick();
        idle();
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("FAIL clear_status: underflow=%b expected 0", underflow);
        end
    endtask

    task automatic test_full_overflow();
        for (int k = 0; k < DEPTH; k++) push(100 + k, k, 2 * k, k, 1'b0, 1'b0);
        checks++;
        if (enq_ready !== 1'b0 || pending_count !== CW'(DEPTH) || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full: enq_ready=%b pending=%0d overflow=%b expected 0 %0d 0",
                     enq_ready, pending_count, overflow, DEPTH);
        end
        push(8'hEE, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || pending_count !== CW'(DEPTH)) begin
            errors++;
            $display("FAIL overflow: overflow=%b pending=%0d expected 1 %0d", overflow, pending_count, DEPTH);
        end
        commit = 1'b1;
        tick();
        idle();
        checks++;
        if (enq_ready !== 1'b0 || visible_count !== CW'(DEPTH) || pending_count !== CW'(0)) begin
            errors++;
            $display("FAIL commit_full: enq_ready=%b visible=%0d pending=%0d expected 0 %0d 0",
                     enq_ready, visible_count, pending_count, DEPTH);
        end
        // A pop in the same cycle does not make room for that cycle's enqueue.
        push(8'hAA, 0, 0, 0, 1'b0, 1'b1);
        checks++;
        if (visible_count !== CW'(DEPTH - 1) || pending_count !== CW'(0) || enq_ready !== 1'b1 ||
            head_id !== ID_W'(101)) begin
            errors++;
            $display("FAIL deq_while_full: visible=%0d pending=%0d enq_ready=%b id=%0d expected %0d 0 1 101",
                     visible_count, pending_count, enq_ready, head_id, DEPTH - 1);
        end
        // Back-to-back pops, one per cycle.
        for (int j = 1; j < DEPTH; j++) begin
            checks++;
            if (head_id !== ID_W'(100 + j)) begin
                errors++;
                $display("FAIL b2b_pop%0d: id=%0d expected %0d", j, head_id, 100 + j);
            end
            dequeue = 1'b1;
            tick();
        end
        idle();
        checks++;
        if (is_empty !== 1'b1 || visible_count !== CW'(0) || underflow !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drained: is_empty=%b visible=%0d underflow=%b expected 1 0 0",
                     is_empty, visible_count, underflow);
        end
        clear_status = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_same_cycle_commit();
        push(7, 70, 71, 72, 1'b1, 1'b0);
        checks++;
        if (is_empty !== 1'b0 || head_id !== ID_W'(7) || visible_count !== CW'(1) ||
            pending_count !== CW'(0)) begin
            errors++;
            $display("FAIL enq_commit: is_empty=%b id=%0d visible=%0d pending=%0d expected 0 7 1 0",
                     is_empty, head_id, visible_count, pending_count);
        end
        // Enqueue, commit and dequeue in one cycle all take effect.
        push(8, 80, 81, 82, 1'b1, 1'b1);
        checks++;
        if (head_id !== ID_W'(8) || head_x !== COORD_W'(80) || visible_count !== CW'(1) ||
            pending_count !== CW'(0) || underflow !== 1'b0) begin
            errors++;
            $display("FAIL enq_commit_deq: id=%0d x=%0d visible=%0d pending=%0d underflow=%b expected 8 80 1 0 0",
                     head_id, head_x, visible_count, pending_count, underflow);
        end
        dequeue = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_wrap();
        int bad = 0;
        for (int it = 0; it < 200; it++) begin
            for (int j = 0; j < 50; j++) push(it * 50 + j, it, j, it + j, 1'b0, 1'b0);
            commit = 1'b1;
            tick();
            idle();
            checks++;
            if (visible_count !== CW'(50) || pending_count !== CW'(0)) begin
                errors++;
                $display("FAIL wrap_count%0d: visible=%0d pending=%0d expected 50 0",
                         it, visible_count, pending_count);
            end
            for (int j = 0; j < 50; j++) begin
                checks++;
                if (head_id !== ID_W'(it * 50 + j) || head_x !== COORD_W'(it) ||
                    head_y !== COORD_W'(j) || head_scale !== SCALE_W'(it + j)) begin
                    errors++;
                    bad++;
                    if (bad <= 10)
                        $display("FAIL wrap_head it=%0d j=%0d: id=%0d x=%0d y=%0d expected %0d %0d %0d",
                                 it, j, head_id, head_x, head_y, (it * 50 + j) % 256, it, j);
                end
                dequeue = 1'b1;
                tick();
            end
            idle();
        end
        checks++;
        if (is_empty !== 1'b1 || visible_count !== CW'(0) || underflow !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: is_empty=%b visible=%0d underflow=%b overflow=%b expected 1 0 0 0",
                     is_empty, visible_count, underflow, overflow);
        end
    endtask

    task automatic test_flush();
        dequeue = 1'b1;  // sets underflow so flush can be shown to leave it alone
        tick();
        idle();
        for (int i = 0; i < 10; i++) push(i, i, i, i, 1'b0, 1'b0);
        commit = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 5; i++) push(i + 20, 0, 0, 0, 1'b0, 1'b0);
        checks++;
        if (visible_count !== CW'(10) || pending_count !== CW'(5)) begin
            errors++;
            $display("FAIL preflush: visible=%0d pending=%0d expected 10 5", visible_count, pending_count);
        end
        flush = 1'b1;
        push(99, 0, 0, 0, 1'b1, 1'b1);
        checks++;
        if (visible_count !== CW'(0) || pending_count !== CW'(0) || is_empty !== 1'b1 ||
            enq_ready !== 1'b1 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL flush: visible=%0d pending=%0d is_empty=%b enq_ready=%b underflow=%b expected 0 0 1 1 1",
                     visible_count, pending_count, is_empty, enq_ready, underflow);
        end
    endtask

    task automatic test_reset_midstream();
        for (int i = 0; i < 3; i++) push(i + 40, 0, 0, 0, 1'b0, 1'b0);
        commit = 1'b1;
        tick();
        idle();
        push(50, 0, 0, 0, 1'b0, 1'b0);
        reset = 1'b1;
        flush = 1'b1;
        push(51, 0, 0, 0, 1'b1, 1'b1);
        checks++;
        if (is_empty !== 1'b1 || enq_ready !== 1'b1 || visible_count !== CW'(0) ||
            pending_count !== CW'(0) || underflow !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: is_empty=%b enq_ready=%b visible=%0d pending=%0d uf=%b of=%b expected 1 1 0 0 0 0",
                     is_empty, enq_ready, visible_count, pending_count, underflow, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_commit_batch();
        test_pop_order();
        test_full_overflow();
        test_same_cycle_commit();
        test_wrap();
        test_flush();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
